sort_stream_checker: RTL

Sink-side checker for the hardware merge sorter's output stream. It consumes one record per cycle from the merge tree output (`DOT`/`DOTEN`) and verifies that keys are non-decreasing. It also counts records against an expected total, folds every record into an XOR checksum and detects stalls. It replaces the bare XOR-reduction sink in evaluation and board builds, and reports a compact pass/fail status.

---
 rtl/sort_stream_checker.sv | 121 ++++++++++++
 1 files changed

// File: rtl/sort_stream_checker.sv
// Sink-side checker for the merge sorter output stream: verifies non-decreasing keys,
// counts records against an expected total, folds records into an XOR checksum and detects stalls.
module sort_stream_checker #(
    parameter int DATW = 64,
    parameter int KEYW = 32,
    parameter int CNTW = 32,
    parameter int TOW  = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [CNTW-1:0] TOTAL,
    input  logic [DATW-1:0] DIN,
    input  logic            DINEN,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR,
    output logic            OVF,
    output logic            TMO,
    output logic [CNTW-1:0] CNT,
    output logic [CNTW-1:0] ERR_IDX,
    output logic [KEYW-1:0] ERR_KEY,
    output logic [DATW-1:0] CHKSUM
);

    // Stream contract: DIN is consumed on every cycle DINEN is high; there is no backpressure.
    typedef enum logic [1:0] {IDLE, RUN, FIN, FAIL} state_t;

    state_t          state;
    logic [CNTW-1:0] total_q;
    logic [KEYW-1:0] prev_key;
    logic            first;
    logic [TOW-1:0]  idle_cnt;

    logic [KEYW-1:0] key;
    logic            key_lt;
    logic            last_rec;
    logic            cnt_max;

    assign key      = DIN[KEYW-1:0];
    assign key_lt   = !first && (key < prev_key);
    assign cnt_max  = &CNT;
    // One bit wider so a saturated counter never aliases onto TOTAL.
    assign last_rec = (({1'b0, CNT} + (CNTW+1)'(1)) == {1'b0, total_q});
    assign BUSY     = (state == RUN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            total_q  <= '0;
            prev_key <= '0;
            first    <= 1'b0;
            idle_cnt <= '0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            OVF      <= 1'b0;
            TMO      <= 1'b0;
            CNT      <= '0;
            ERR_IDX  <= '0;
            ERR_KEY  <= '0;
            CHKSUM   <= '0;
        end else if (START) begin
            total_q  <= TOTAL;
            prev_key <= '0;
            first    <= 1'b1;
            idle_cnt <= '0;
            ERR      <= 1'b0;
            OVF      <= 1'b0;
            TMO      <= 1'b0;
            CNT      <= '0;
            ERR_IDX  <= '0;
            ERR_KEY  <= '0;
            CHKSUM   <= '0;
            if (TOTAL == '0) begin
                DONE  <= 1'b1;
                state <= FIN;
            end else begin
                DONE  <= 1'b0;
                state <= RUN;
            end
        end else begin
            case (state)
                RUN: begin
                    if (DINEN) begin
                        if (!cnt_max) CNT <= CNT + CNTW'(1);
                        CHKSUM   <= CHKSUM ^ DIN;
                        idle_cnt <= '0;
                        if (key_lt) begin
                            ERR     <= 1'b1;
                            ERR_IDX <= CNT;
                            ERR_KEY <= key;
                            state   <= FAIL;
                        end else begin
                            prev_key <= key;
                            first    <= 1'b0;
                            if (last_rec) begin
                                DONE  <= 1'b1;
                                state <= FIN;
                            end
                        end
                    end else if (&idle_cnt) begin
                        TMO   <= 1'b1;
                        state <= FAIL;
                    end else begin
                        idle_cnt <= idle_cnt + TOW'(1);
                    end
                end
                FIN: begin
                    // Anything beyond the expected total is an overflow and is not folded in.
                    if (DINEN) begin
                        OVF   <= 1'b1;
                        DONE  <= 1'b0;
                        state <= FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
